laser_dist_meter_avg: RTL and testbench

Parametrised successor to the single-shot laser distance measurer HLSM. On a start request it fires a configurable-length laser pulse and counts clock cycles until the sensor sees the reflection. It repeats this for 2^LOG2_AVG shots and publishes the averaged half-round-trip count on D. It adds busy/valid handshaking and a timeout error path for lost echoes, and sits between the user button/sensor front end and the distance display logic.

---
 rtl/laser_dist_meter_avg.sv | 157 +++++++++++++++
 tb/tb_laser_dist_meter_avg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_dist_meter_avg.sv
// laser_dist_meter_avg
//   Averaging laser distance meter. On an accepted start (b) it fires a laser
//   pulse of PULSE_CYC cycles, then counts clock cycles until the reflection
//   sensor (s) goes high. This repeats for 2^LOG2_AVG shots. The summed counts
//   are divided by 2^(LOG2_AVG+1), giving the average half-round-trip count,
//   which is published on D together with a one-cycle valid pulse. A shot whose
//   echo does not arrive within TIMEOUT counts aborts the measurement and sets
//   the sticky err flag.
//
// Ports
//   clk   : clock, rising edge active
//   rst   : asynchronous active-low reset
//   b     : start request, honoured only in IDLE
//   s     : reflection sensor, honoured only in WAIT
//   l     : laser enable, high in every FIRE cycle
//   D     : last valid distance (half-round-trip cycles), WIDTH bits
//   busy  : high in every state except IDLE
//   valid : one-cycle pulse when D is updated
//   err   : timeout flag, sticky until the next accepted start
module laser_dist_meter_avg #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PULSE_CYC = 1,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned LOG2_AVG  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             s,
    output logic             l,
    output logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             valid,
    output logic             err
);

    localparam int unsigned ACC_W  = WIDTH + LOG2_AVG;
    // Keep the shot counter at least one bit wide even for single-shot builds.
    localparam int unsigned SHOT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    localparam logic [SHOT_W-1:0] LAST_SHOT  = SHOT_W'((1 << LOG2_AVG) - 1);
    localparam logic [7:0]        PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [WIDTH-1:0]  DCTR_MAX   = WIDTH'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StFire = 3'd1,
        StWait = 3'd2,
        StAcc  = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   dctr_q;
    logic [ACC_W-1:0]   acc_q;
    logic [SHOT_W-1:0]  shot_q;
    logic [7:0]         pctr_q;

    // Running sum including the shot being accumulated this cycle; on the last
    // shot it is scaled straight into D so that D and valid appear together.
    logic [ACC_W-1:0]   acc_sum;

    assign acc_sum = acc_q + ACC_W'(dctr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dctr_q  <= '0;
            acc_q   <= '0;
            shot_q  <= '0;
            pctr_q  <= '0;
            l       <= 1'b0;
            D       <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (b) begin
                        state_q <= StFire;
                        acc_q   <= '0;
                        shot_q  <= '0;
                        pctr_q  <= '0;
                        dctr_q  <= '0;
                        err     <= 1'b0;
                        l       <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                StFire: begin
                    if (pctr_q == PULSE_LAST) begin
                        state_q <= StWait;
                        pctr_q  <= '0;
                        l       <= 1'b0;
                    end else begin
                        pctr_q <= pctr_q + 8'd1;
                    end
                end

                StWait: begin
                    // Echo has priority over timeout when both coincide.
                    if (s) begin
                        state_q <= StAcc;
                    end else if (dctr_q == DCTR_MAX) begin
                        state_q <= StErr;
                        err     <= 1'b1;
                    end else begin
                        dctr_q <= dctr_q + WIDTH'(1);
                    end
                end

                StAcc: begin
                    acc_q <= acc_sum;
                    if (shot_q == LAST_SHOT) begin
                        state_q <= StDone;
                        D       <= WIDTH'(acc_sum >> (LOG2_AVG + 1));
                        valid   <= 1'b1;
                    end else begin
                        // Re-fire automatically for the next shot.
                        state_q <= StFire;
                        shot_q  <= shot_q + SHOT_W'(1);
                        pctr_q  <= '0;
                        dctr_q  <= '0;
                        l       <= 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end

                StErr: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end

                default: begin
                    // Illegal encoding: recover to IDLE, holding only D.
                    state_q <= StIdle;
                    dctr_q  <= '0;
                    acc_q   <= '0;
                    shot_q  <= '0;
                    pctr_q  <= '0;
                    l       <= 1'b0;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_dist_meter_avg.sv
// Testbench for laser_dist_meter_avg. Two instances: a single-shot build
// (PULSE_CYC=1, LOG2_AVG=0) and an averaging build (PULSE_CYC=3, LOG2_AVG=2),
// both with TIMEOUT=20. Stimulus is generated per measurement as a timeline
// (start, pulse, echo delay, accumulate, result); the expected outputs of every
// cycle follow from that timeline, and the reported distance from the sum of
// echo delays. A compare process checks the active instance on each negedge.
module tb_laser_dist_meter_avg;

    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst;
    logic b, s, sel;
    logic b0, s0, b1, s1;
    logic l0, busy0, valid0, err0;
    logic l1, busy1, valid1, err1;
    logic [15:0] d0, d1;
    logic l_m, busy_m, valid_m, err_m;
    logic [15:0] d_m;

    assign b0 = sel ? 1'b0 : b;
    assign s0 = sel ? 1'b0 : s;
    assign b1 = sel ? b : 1'b0;
    assign s1 = sel ? s : 1'b0;

    assign l_m     = sel ? l1 : l0;
    assign busy_m  = sel ? busy1 : busy0;
    assign valid_m = sel ? valid1 : valid0;
    assign err_m   = sel ? err1 : err0;
    assign d_m     = sel ? d1 : d0;

    laser_dist_meter_avg #(
        .WIDTH(16), .PULSE_CYC(1), .TIMEOUT(TMO), .LOG2_AVG(0)
    ) dut0 (
        .clk(clk), .rst(rst), .b(b0), .s(s0),
        .l(l0), .D(d0), .busy(busy0), .valid(valid0), .err(err0)
    );

    laser_dist_meter_avg #(
        .WIDTH(16), .PULSE_CYC(3), .TIMEOUT(TMO), .LOG2_AVG(2)
    ) dut1 (
        .clk(clk), .rst(rst), .b(b1), .s(s1),
        .l(l1), .D(d1), .busy(busy1), .valid(valid1), .err(err1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic exp_l, exp_busy, exp_valid, exp_err;
    logic [15:0] exp_d;
    logic [15:0] cur_d;
    logic cur_err;
    int cur_p, cur_l2;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic logic nz(input bit en);
        return en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("l", 32'(l_m), 32'(exp_l));
            chk("busy", 32'(busy_m), 32'(exp_busy));
            chk("valid", 32'(valid_m), 32'(exp_valid));
            chk("err", 32'(err_m), 32'(exp_err));
            chk("D", 32'(d_m), 32'(exp_d));
        end
    end

    // One cycle: drive inputs and declare the outputs expected in this cycle.
    // Entered and left at posedge+1.
    task automatic step(input logic ib, input logic is, input logic el, input logic eb,
                        input logic ev, input logic ee, input logic [15:0] ed);
        b = ib;
        s = is;
        exp_l = el;
        exp_busy = eb;
        exp_valid = ev;
        exp_err = ee;
        exp_d = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, nz(1'b1), 1'b0, 1'b0, 1'b0, cur_err, cur_d);
    endtask

    // One full measurement starting from an IDLE cycle. to_shot / abort_shot
    // select a shot that times out or is cut by reset (-1 for none).
    task automatic run_meas(input bit hold, input bit noise, input int to_shot,
                            input int abort_shot, input bit fixed,
                            input int f0, input int f1, input int f2, input int f3);
        int nsh, n, sum;
        nsh = 1 << cur_l2;
        sum = 0;
        step(1'b1, nz(noise), 1'b0, 1'b0, 1'b0, cur_err, cur_d);
        for (int k = 0; k < nsh; k++) begin
            for (int p = 0; p < cur_p; p++) begin
                if (k == abort_shot && p == 1) begin
                    b = 1'b0;
                    s = 1'b0;
                    #1;
                    chk("pre_rst_l", 32'(l_m), 32'd1);
                    rst = 1'b0;
                    #1;
                    chk("async_l", 32'(l_m), 32'd0);
                    chk("async_busy", 32'(busy_m), 32'd0);
                    chk("async_D", 32'(d_m), 32'd0);
                    chk("async_err", 32'(err_m), 32'd0);
                    exp_l = 1'b0;
                    exp_busy = 1'b0;
                    exp_valid = 1'b0;
                    exp_err = 1'b0;
                    exp_d = 16'd0;
                    @(posedge clk);
                    #1;
                    rst = 1'b1;
                    cur_d = 16'd0;
                    cur_err = 1'b0;
                    return;
                end
                step(nz(noise), nz(noise), 1'b1, 1'b1, 1'b0, 1'b0, cur_d);
            end
            if (k == to_shot) begin
                for (int w = 0; w <= TMO; w++)
                    step(nz(noise), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_d);
                step(nz(noise), nz(noise), 1'b0, 1'b1, 1'b0, 1'b1, cur_d);
                cur_err = 1'b1;
                return;
            end
            if (fixed) begin
                case (k)
                    0: n = f0;
                    1: n = f1;
                    2: n = f2;
                    default: n = f3;
                endcase
            end else begin
                n = int'($urandom_range(0, TMO));
            end
            for (int w = 0; w < n; w++) step(nz(noise), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_d);
            step(nz(noise), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cur_d);
            sum += n;
            step(nz(noise), nz(noise), 1'b0, 1'b1, 1'b0, 1'b0, cur_d);
        end
        cur_d = 16'(sum >> (cur_l2 + 1));
        cur_err = 1'b0;
        step(hold ? 1'b1 : nz(noise), nz(noise), 1'b0, 1'b1, 1'b1, 1'b0, cur_d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        int to;
        sel = 1'b0;
        cur_p = 1;
        cur_l2 = 0;
        b = 1'b0;
        s = 1'b0;
        cur_d = 16'd0;
        cur_err = 1'b0;
        exp_l = 1'b0;
        exp_busy = 1'b0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        exp_d = 16'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_l0", 32'(l0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_D0", 32'(d0), 32'd0);
        chk("rst_l1", 32'(l1), 32'd0);
        chk("rst_D1", 32'(d1), 32'd0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        idle(2);

        // Single-shot build: directed cases pinned to hand-computed values.
        run_meas(1'b0, 1'b0, -1, -1, 1'b1, 10, 0, 0, 0);
        chk("pin_n10", 32'(d_m), 32'd5);
        idle(3);
        run_meas(1'b0, 1'b0, -1, -1, 1'b1, 11, 0, 0, 0);
        chk("pin_n11", 32'(d_m), 32'd5);
        idle(1);
        run_meas(1'b0, 1'b0, -1, -1, 1'b1, 0, 0, 0, 0);
        chk("pin_n0", 32'(d_m), 32'd0);
        idle(1);
        run_meas(1'b0, 1'b1, -1, -1, 1'b1, 11, 0, 0, 0);
        run_meas(1'b0, 1'b0, 0, -1, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_err, cur_d);
        chk("pin_to_err", 32'(err_m), 32'd1);
        chk("pin_to_D", 32'(d_m), 32'd5);
        idle(2);
        run_meas(1'b1, 1'b0, -1, -1, 1'b1, 4, 0, 0, 0);
        run_meas(1'b0, 1'b0, -1, -1, 1'b1, TMO, 0, 0, 0);
        chk("pin_n20", 32'(d_m), 32'd10);

        for (int i = 0; i < 20; i++) begin
            hold = 1'($urandom_range(0, 1));
            to = ($urandom_range(0, 4) == 0) ? 0 : -1;
            run_meas(hold, 1'b1, to, -1, 1'b0, 0, 0, 0, 0);
            if (!hold || to >= 0) idle(int'($urandom_range(0, 3)));
        end

        // Averaging build.
        sel = 1'b1;
        cur_p = 3;
        cur_l2 = 2;
        cur_d = 16'd0;
        cur_err = 1'b0;
        idle(2);
        run_meas(1'b0, 1'b0, -1, -1, 1'b1, 10, 12, 14, 16);
        chk("pin_avg", 32'(d_m), 32'd6);
        idle(2);
        run_meas(1'b0, 1'b1, 2, -1, 1'b0, 0, 0, 0, 0);
        idle(1);
        chk("pin_avg_to_D", 32'(d_m), 32'd6);

        for (int i = 0; i < 15; i++) begin
            hold = 1'($urandom_range(0, 1));
            to = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_meas(hold, 1'b1, to, -1, 1'b0, 0, 0, 0, 0);
            if (!hold || to >= 0) idle(int'($urandom_range(0, 3)));
        end

        idle(1);
        run_meas(1'b0, 1'b0, -1, 2, 1'b1, 10, 12, 14, 16);
        idle(1);
        run_meas(1'b1, 1'b0, -1, -1, 1'b1, 10, 12, 14, 16);
        chk("pin_after_rst", 32'(d_m), 32'd6);
        run_meas(1'b0, 1'b1, -1, -1, 1'b1, 0, 1, 2, 4);
        chk("pin_avg_small", 32'(d_m), 32'd0);
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
